// File: rtl/lbp_image_engine_if.sv
// -----------------------------------------------------------------------------
// lbp_image_engine_if
// Bundles the frame handshake, the source-BRAM read port and the destination
// write port of lbp_image_engine.
//   start        : one-cycle frame request (to engine)
//   cmd[1:0]     : output mode, sampled with an accepted start (to engine)
//   r_addr       : source-BRAM read address (from engine)
//   r_data       : source-BRAM read data (to engine)
//   o_addr       : destination write address (from engine)
//   data_out     : destination write data (from engine)
//   output_valid : destination write strobe (from engine)
//   busy, done   : frame status (from engine)
// Modports: master = engine side, slave = memory/controller side.
// -----------------------------------------------------------------------------
interface lbp_image_engine_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 19
);
    logic                  start;
    logic [1:0]            cmd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  output_valid;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, cmd, r_data,
        output r_addr, o_addr, data_out, output_valid, busy, done
    );

    modport slave (
        output start, cmd, r_data,
        input  r_addr, o_addr, data_out, output_valid, busy, done
    );
endinterface

// File: rtl/lbp_image_engine.sv
// -----------------------------------------------------------------------------
// lbp_image_engine
// Scans an IMG_W x IMG_H frame from the source BRAM and writes one LBP-derived
// word per pixel to the processing memory.
//   clk_p : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : lbp_image_engine_if.master (start/cmd/busy/done handshake,
//           r_addr/r_data read port, o_addr/data_out/output_valid write port)
// Build option: define LBP_BORDER_WRITE_EN to also write border pixels
// (value 0); otherwise border pixels are skipped without a write.
// -----------------------------------------------------------------------------
module lbp_image_engine #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 19,
    parameter int IMG_W      = 300,
    parameter int IMG_H      = 400,
    parameter int RD_LAT     = 1
) (
    input  logic               clk_p,
    input  logic               rst_n,
    lbp_image_engine_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] W_A      = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] W_LAST   = ADDR_WIDTH'(IMG_W - 1);
    localparam logic [ADDR_WIDTH-1:0] H_LAST   = ADDR_WIDTH'(IMG_H - 1);
    localparam logic [ADDR_WIDTH-1:0] LIN_LAST = ADDR_WIDTH'(IMG_W * IMG_H - 1);
    localparam logic [1:0]            WAIT_END = 2'(RD_LAT - 1);

    if (DATA_WIDTH < 8) begin : g_bad_dw
        $error("lbp_image_engine: DATA_WIDTH must be >= 8");
    end
    if (IMG_W < 3 || IMG_H < 3) begin : g_bad_dim
        $error("lbp_image_engine: IMG_W and IMG_H must be >= 3");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("lbp_image_engine: RD_LAT must be in 1..4");
    end
    if (64'(IMG_W) * 64'(IMG_H) > (64'd1 << ADDR_WIDTH)) begin : g_bad_aw
        $error("lbp_image_engine: IMG_W*IMG_H does not fit in ADDR_WIDTH");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CLASSIFY, S_ISSUE, S_WAIT, S_PROC, S_WRITE, S_DONE
    } state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_cmd;
    logic [ADDR_WIDTH-1:0] r_x, r_y, r_lin;
    logic [3:0]            r_idx;
    logic [1:0]            r_wcnt;
    logic [7:0]            r_code;
    logic [DATA_WIDTH-1:0] r_gc;
    logic [ADDR_WIDTH-1:0] r_raddr, r_oaddr;
    logic [DATA_WIDTH-1:0] r_dout;

    logic       w_border, w_last_pix, w_wait_end, w_advance;
    logic       w_valid, w_done, w_busy;
    logic [2:0] w_bit;

    // Neighbour address for read slot idx, relative to the centre pixel.
    function automatic logic [ADDR_WIDTH-1:0] nbr_addr(
        input logic [ADDR_WIDTH-1:0] lin, input logic [3:0] idx);
        case (idx)
            4'd1:    return lin - W_A - A_ONE;
            4'd2:    return lin - W_A;
            4'd3:    return lin - W_A + A_ONE;
            4'd4:    return lin - A_ONE;
            4'd5:    return lin + A_ONE;
            4'd6:    return lin + W_A - A_ONE;
            4'd7:    return lin + W_A;
            4'd8:    return lin + W_A + A_ONE;
            default: return lin;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] form_result(
        input logic [1:0] cmd, input logic [7:0] code, input logic [DATA_WIDTH-1:0] gc);
        logic [7:0] ncode;
        ncode = ~code;
        case (cmd)
            2'd0:    return DATA_WIDTH'(code);
            2'd1:    return '1;
            2'd2:    return gc;
            default: return DATA_WIDTH'(ncode);
        endcase
    endfunction

    assign w_border   = (r_x == '0) || (r_x == W_LAST) || (r_y == '0) || (r_y == H_LAST);
    assign w_last_pix = (r_lin == LIN_LAST);
    assign w_wait_end = (r_wcnt == WAIT_END);
    assign w_bit      = 3'(r_idx - 4'd1);

`ifdef LBP_BORDER_WRITE_EN
    assign w_advance = (r_state == S_WRITE);
`else
    // Skipped border pixels move on straight from CLASSIFY.
    assign w_advance = (r_state == S_WRITE) || (r_state == S_CLASSIFY && w_border);
`endif

    // State register
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (bus.start) w_next = S_CLASSIFY;
            S_CLASSIFY: begin
                if (!w_border)       w_next = S_ISSUE;
`ifdef LBP_BORDER_WRITE_EN
                else                 w_next = S_WRITE;
`else
                else if (w_last_pix) w_next = S_DONE;
                else                 w_next = S_CLASSIFY;
`endif
            end
            S_ISSUE:    w_next = S_WAIT;
            S_WAIT:     if (w_wait_end) w_next = (r_idx == 4'd8) ? S_PROC : S_ISSUE;
            S_PROC:     w_next = S_WRITE;
            S_WRITE:    w_next = w_last_pix ? S_DONE : S_CLASSIFY;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Output decode; busy is already low in the DONE cycle
    always_comb begin
        w_valid = 1'b0;
        w_done  = 1'b0;
        w_busy  = 1'b1;
        case (r_state)
            S_IDLE:  w_busy = 1'b0;
            S_WRITE: w_valid = 1'b1;
            S_DONE:  begin w_done = 1'b1; w_busy = 1'b0; end
            default: ;
        endcase
    end

    assign bus.output_valid = w_valid;
    assign bus.done         = w_done;
    assign bus.busy         = w_busy;
    assign bus.r_addr       = r_raddr;
    assign bus.o_addr       = r_oaddr;
    assign bus.data_out     = r_dout;

    // Frame position: x/y/lin advance together, no divide needed
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0; r_y <= '0; r_lin <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_x <= '0; r_y <= '0; r_lin <= '0;
        end else if (w_advance) begin
            r_lin <= r_lin + A_ONE;
            if (r_x == W_LAST) begin
                r_x <= '0;
                r_y <= r_y + A_ONE;
            end else begin
                r_x <= r_x + A_ONE;
            end
        end
    end

    // Datapath: r_addr is loaded on entry to ISSUE so it is stable for the
    // ISSUE cycle plus all RD_LAT wait cycles; o_addr/data_out load on entry
    // to WRITE and hold afterwards.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd <= '0; r_idx <= '0; r_wcnt <= '0; r_code <= '0; r_gc <= '0;
            r_raddr <= '0; r_oaddr <= '0; r_dout <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) r_cmd <= bus.cmd;
                S_CLASSIFY: begin
                    if (!w_border) begin
                        r_idx   <= '0;
                        r_code  <= '0;
                        r_raddr <= r_lin;
                    end
`ifdef LBP_BORDER_WRITE_EN
                    else begin
                        r_oaddr <= r_lin;
                        r_dout  <= '0;
                    end
`endif
                end
                S_ISSUE: r_wcnt <= '0;
                S_WAIT: begin
                    if (w_wait_end) begin
                        if (r_idx == 4'd0)             r_gc <= bus.r_data;
                        else if (bus.r_data >= r_gc)   r_code[w_bit] <= 1'b1;
                        if (r_idx != 4'd8) begin
                            r_idx   <= r_idx + 4'd1;
                            r_raddr <= nbr_addr(r_lin, r_idx + 4'd1);
                        end
                    end else begin
                        r_wcnt <= r_wcnt + 2'd1;
                    end
                end
                S_PROC: begin
                    r_oaddr <= r_lin;
                    r_dout  <= form_result(r_cmd, r_code, r_gc);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lbp_image_engine.sv
module tb_lbp_image_engine;
    localparam int DW = 12;
    localparam int AW = 19;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lbp_image_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
    lbp_image_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

    lbp_image_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(4), .IMG_H(4), .RD_LAT(1))
        dut_a (.clk_p(clk), .rst_n(rst_n), .bus(ifa));
    lbp_image_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_W(4), .IMG_H(4), .RD_LAT(3))
        dut_b (.clk_p(clk), .rst_n(rst_n), .bus(ifb));

    // Shared 4x4 source image, separate read pipelines per latency
    logic [DW-1:0] mem [16];
    logic [DW-1:0] pa0, pb0, pb1, pb2;
    always @(posedge clk) begin
        pa0 <= mem[ifa.r_addr[3:0]];
        pb0 <= mem[ifb.r_addr[3:0]];
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign ifa.r_data = pa0;
    assign ifb.r_data = pb2;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          vld;
        logic          done;
        logic          busy;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [AW-1:0] raddr;
    } smp_t;

    function automatic smp_t smp(input int which);
        smp_t s;
        if (which == 0) begin
            s.vld = ifa.output_valid; s.done = ifa.done; s.busy = ifa.busy;
            s.addr = ifa.o_addr; s.data = ifa.data_out; s.raddr = ifa.r_addr;
        end else begin
            s.vld = ifb.output_valid; s.done = ifb.done; s.busy = ifb.busy;
            s.addr = ifb.o_addr; s.data = ifb.data_out; s.raddr = ifb.r_addr;
        end
        return s;
    endfunction

    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int ra_val[$];
    int ra_dur[$];
    int done_cnt;
    bit busy_at_done;

    task automatic set_pat(input int p);
        for (int a = 0; a < 16; a++) begin
            case (p)
                0:       mem[a] = 12'h123;
                1:       mem[a] = 12'(a);
                2:       mem[a] = 12'(15 - a);
                default: mem[a] = 12'h800;
            endcase
        end
        if (p == 3) begin
            mem[0] = 12'h7FF; mem[15] = 12'hFFF; mem[6] = 12'h000;
        end
    endtask

    task automatic start_frame(input int which, input logic [1:0] c);
        @(negedge clk);
        if (which == 0) begin ifa.cmd = c; ifa.start = 1'b1; end
        else            begin ifb.cmd = c; ifb.start = 1'b1; end
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        chk("busy_after_start", (which == 0) ? ifa.busy : ifb.busy, 1);
    endtask

    // Samples one DUT every negedge; optional early stop after stop_wr writes
    // and an optional one-cycle start pulse at iteration poke_at.
    task automatic capture(input int which, input int budget, input int tail,
                           input int stop_wr, input int poke_at, output bit got_done);
        smp_t s;
        int after = 0;
        int prev_ra = -1;
        got_done = 1'b0;
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        ra_val.delete(); ra_dur.delete();
        done_cnt = 0;
        busy_at_done = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            s = smp(which);
            if (s.vld) begin
                wr_addr.push_back(int'(s.addr));
                wr_data.push_back(int'(s.data));
                wr_cyc.push_back(c);
            end
            if (int'(s.raddr) == prev_ra) begin
                ra_dur[ra_dur.size()-1] = ra_dur[ra_dur.size()-1] + 1;
            end else begin
                ra_val.push_back(int'(s.raddr));
                ra_dur.push_back(1);
                prev_ra = int'(s.raddr);
            end
            if (got_done) after++;
            if (s.done) begin
                if (!got_done) busy_at_done = s.busy;
                done_cnt++;
                got_done = 1'b1;
            end
            if (which == 0) ifa.start = (c == poke_at);
            else            ifb.start = (c == poke_at);
            if (got_done && after >= tail) break;
            if (stop_wr > 0 && wr_addr.size() >= stop_wr) break;
        end
    endtask

    // e holds the expected words for interior addresses 5, 6, 9, 10 in order
    task automatic check_writes(input string tag, input logic [0:3][11:0] e, input int spacing);
        int ea[$];
        int ed[$];
        int k = 0;
        int i5 = 0, i6 = 0, i9 = 0, i10 = 0;
        for (int a = 0; a < 16; a++) begin
            if ((a % 4) > 0 && (a % 4) < 3 && (a / 4) > 0 && (a / 4) < 3) begin
                if (a == 5)  i5  = ea.size();
                if (a == 6)  i6  = ea.size();
                if (a == 9)  i9  = ea.size();
                if (a == 10) i10 = ea.size();
                ea.push_back(a);
                ed.push_back(int'(e[k]));
                k++;
            end
`ifdef LBP_BORDER_WRITE_EN
            else begin
                ea.push_back(a);
                ed.push_back(0);
            end
`endif
        end
        chk({tag, " n_writes"}, wr_addr.size(), ea.size());
        for (int i = 0; i < ea.size(); i++) begin
            if (i < wr_addr.size()) begin
                chk($sformatf("%s addr[%0d]", tag, i), wr_addr[i], ea[i]);
                chk($sformatf("%s data@%0d", tag, ea[i]), wr_data[i], ed[i]);
            end
        end
        if (i10 < wr_cyc.size()) begin
            chk({tag, " spacing5_6"}, wr_cyc[i6] - wr_cyc[i5], spacing);
            chk({tag, " spacing9_10"}, wr_cyc[i10] - wr_cyc[i9], spacing);
        end
    endtask

    task automatic chk_quiet(input string tag, input int which);
        smp_t s;
        s = smp(which);
        chk({tag, " output_valid"}, s.vld, 0);
        chk({tag, " done"}, s.done, 0);
        chk({tag, " busy"}, s.busy, 0);
        chk({tag, " o_addr"}, 32'(s.addr), 0);
        chk({tag, " data_out"}, 32'(s.data), 0);
        chk({tag, " r_addr"}, 32'(s.raddr), 0);
    endtask

    typedef struct {
        int               pat;
        logic [1:0]       cmd;
        logic [0:3][11:0] exp;
    } vec_t;

    function automatic vec_t mk(input int p, input logic [1:0] c,
                                input logic [11:0] e5, input logic [11:0] e6,
                                input logic [11:0] e9, input logic [11:0] e10);
        vec_t v;
        v.pat = p; v.cmd = c; v.exp = {e5, e6, e9, e10};
        return v;
    endfunction

    vec_t vecs[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit gd;
        rst_n = 1'b0;
        ifa.start = 1'b0; ifa.cmd = 2'd0;
        ifb.start = 1'b0; ifb.cmd = 2'd0;
        set_pat(0);

        // pattern 0: flat 0x123; 1: value=address; 2: value=15-address;
        // 3: 0x800 field with 0x7FF at 0, 0x000 at 6, 0xFFF at 15
        vecs[0] = mk(0, 2'd0, 12'h0FF, 12'h0FF, 12'h0FF, 12'h0FF);
        vecs[1] = mk(1, 2'd0, 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0);
        vecs[2] = mk(1, 2'd3, 12'h00F, 12'h00F, 12'h00F, 12'h00F);
        vecs[3] = mk(1, 2'd1, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        vecs[4] = mk(1, 2'd2, 12'h005, 12'h006, 12'h009, 12'h00A);
        vecs[5] = mk(2, 2'd0, 12'h00F, 12'h00F, 12'h00F, 12'h00F);
        vecs[6] = mk(2, 2'd2, 12'h00A, 12'h009, 12'h006, 12'h005);
        vecs[7] = mk(3, 2'd0, 12'h0EE, 12'h0FF, 12'h0FB, 12'h0FD);
        vecs[8] = mk(3, 2'd3, 12'h011, 12'h000, 12'h004, 12'h002);
        vecs[9] = mk(3, 2'd2, 12'h800, 12'h000, 12'h800, 12'h800);

        repeat (3) @(negedge clk);
        chk_quiet("reset_a", 0);
        chk_quiet("reset_b", 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            set_pat(vecs[v].pat);
            start_frame(0, vecs[v].cmd);
            capture(0, 300, 5, 0, -1, gd);
            chk($sformatf("v%0d done_seen", v), gd, 1);
            chk($sformatf("v%0d done_count", v), done_cnt, 1);
            chk($sformatf("v%0d busy_low_at_done", v), busy_at_done, 0);
            check_writes($sformatf("v%0d", v), vecs[v].exp, 21);
        end

        // RD_LAT=3: read spacing, address hold time, start ignored while busy
        set_pat(1);
        start_frame(1, 2'd0);
        capture(1, 500, 40, 0, 60, gd);
        chk("lat3 done_seen", gd, 1);
        chk("lat3 done_count", done_cnt, 1);
        check_writes("lat3", {12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0}, 39);
        chk("lat3 ra_runs", (ra_val.size() >= 10), 1);
        if (ra_val.size() >= 10) begin
            chk("lat3 ra_first", ra_val[0], 0);
            chk("lat3 ra[1]", ra_val[1], 5);
            chk("lat3 ra[2]", ra_val[2], 0);
            chk("lat3 ra[3]", ra_val[3], 1);
            chk("lat3 ra[4]", ra_val[4], 2);
            chk("lat3 ra[5]", ra_val[5], 4);
            chk("lat3 ra[6]", ra_val[6], 6);
            chk("lat3 ra[7]", ra_val[7], 8);
            chk("lat3 ra[8]", ra_val[8], 9);
            chk("lat3 ra[9]", ra_val[9], 10);
            for (int i = 1; i <= 8; i++) chk($sformatf("lat3 hold[%0d]", i), ra_dur[i], 4);
        end

        // start coinciding with done is dropped; start one cycle later is taken
        set_pat(2);
        start_frame(0, 2'd0);
        capture(0, 300, 0, 0, -1, gd);
        chk("dstart first done", gd, 1);
        ifa.cmd = 2'd2;
        ifa.start = 1'b1;
        @(negedge clk);
        chk("dstart ignored busy", ifa.busy, 0);
        @(negedge clk);
        ifa.start = 1'b0;
        chk("dstart accepted busy", ifa.busy, 1);
        capture(0, 300, 5, 0, -1, gd);
        chk("dstart second done", gd, 1);
        chk("dstart done_count", done_cnt, 1);
        check_writes("dstart", {12'h00A, 12'h009, 12'h006, 12'h005}, 21);

        // reset in the middle of a frame, then a clean rerun
        set_pat(1);
        start_frame(0, 2'd0);
        capture(0, 300, 0, 2, -1, gd);
        chk("midrst writes_before", wr_addr.size(), 2);
        chk("midrst valid_before", ifa.output_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_quiet("midrst async", 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("midrst idle", 0);
        start_frame(0, 2'd0);
        capture(0, 300, 5, 0, -1, gd);
        chk("midrst rerun done", gd, 1);
        chk("midrst rerun done_count", done_cnt, 1);
        check_writes("midrst", {12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0}, 21);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
